// File: rtl/drv_led_pkg.sv
// Shared constants and state type for the LED pin driver.
package pkg_drv_led;

    localparam int unsigned LED_ACTIVE_HIGH = 0;
    localparam int unsigned LED_ACTIVE_LOW  = 1;

    typedef enum logic [1:0] {
        S_OFF,
        S_ON,
        S_FL_ON,
        S_FL_OFF
    } t_led_state;

endpackage

// File: rtl/drv_led_pwm_gen.sv
// Brightness PWM: free-running counter over 0 .. 2^p_pwm_w - 2 compared against a live level.
module pwm_gen #(
    parameter int unsigned p_pwm_w = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [p_pwm_w-1:0] i_level,
    output logic               o_pwm
);

    // One short of all-ones so an all-ones level is on for the whole period.
    localparam logic [p_pwm_w-1:0] CNT_MAX = {{(p_pwm_w-1){1'b1}}, 1'b0};
    localparam logic [p_pwm_w-1:0] CNT_ONE = {{(p_pwm_w-1){1'b0}}, 1'b1};

    logic [p_pwm_w-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign o_pwm = (cnt_q < i_level);

endmodule

// File: rtl/drv_led.sv
// LED pin driver: steady on/off/toggle, finite or continuous flashing, PWM brightness,
// with build-time pin polarity.
module drv_led
    import pkg_drv_led::*;
#(
    parameter int unsigned p_scale = 5,
    parameter int unsigned p_mode  = LED_ACTIVE_HIGH,
    parameter int unsigned p_pwm_w = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_on,
    input  logic               i_off,
    input  logic               i_toggle,
    input  logic               i_flash,
    input  logic [3:0]         i_count,
    input  logic [7:0]         i_half,
    input  logic [p_pwm_w-1:0] i_level,
    output logic               o_drv_led,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic               DARK      = (p_mode == LED_ACTIVE_LOW);
    localparam logic [p_scale-1:0] PRESC_ONE = {{(p_scale-1){1'b0}}, 1'b1};

    t_led_state         state;
    logic [p_scale-1:0] presc;
    logic [7:0]         phase;
    logic [7:0]         half;
    logic [3:0]         count;
    logic               pwm;
    logic               tick;
    logic               phase_end;
    logic               lit;
    logic [7:0]         half_in;

    pwm_gen #(
        .p_pwm_w(p_pwm_w)
    ) u_pwm (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_level(i_level),
        .o_pwm  (pwm)
    );

    assign tick      = &presc;
    assign phase_end = tick && (phase == half - 8'd1);
    assign half_in   = (i_half == 8'd0) ? 8'd1 : i_half;
    assign lit       = ((state == S_ON) || (state == S_FL_ON)) && pwm;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= S_OFF;
            presc     <= '0;
            phase     <= '0;
            half      <= 8'd1;
            count     <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_drv_led <= DARK;
        end else begin
            presc     <= presc + PRESC_ONE;
            o_done    <= 1'b0;
            o_drv_led <= lit ^ DARK;

            if (i_off) begin
                state  <= S_OFF;
                o_busy <= 1'b0;
            end else if (i_on) begin
                state  <= S_ON;
                o_busy <= 1'b0;
            end else if (i_flash) begin
                // Restart timing from zero so every phase is exactly half ticks long.
                count  <= i_count;
                half   <= half_in;
                presc  <= '0;
                phase  <= '0;
                state  <= S_FL_ON;
                o_busy <= 1'b1;
            end else begin
                case (state)
                    S_OFF: begin
                        if (i_toggle) state <= S_ON;
                    end
                    S_ON: begin
                        if (i_toggle) state <= S_OFF;
                    end
                    S_FL_ON: begin
                        if (phase_end) begin
                            phase <= '0;
                            state <= S_FL_OFF;
                        end else if (tick) begin
                            phase <= phase + 8'd1;
                        end
                    end
                    S_FL_OFF: begin
                        if (phase_end) begin
                            phase <= '0;
                            if (count == 4'd0) begin
                                state <= S_FL_ON;
                            end else if (count == 4'd1) begin
                                count  <= 4'd0;
                                state  <= S_OFF;
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                            end else begin
                                count <= count - 4'd1;
                                state <= S_FL_ON;
                            end
                        end else if (tick) begin
                            phase <= phase + 8'd1;
                        end
                    end
                    default: state <= S_OFF;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_drv_led.sv
// Directed bench for drv_led: vector table for command handling plus timed flash/PWM/reset runs.
module tb_drv_led;
    import pkg_drv_led::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       on = 1'b0, off = 1'b0, tog = 1'b0, fl = 1'b0;
    logic [3:0] count = 4'd1;
    logic [7:0] half = 8'd1;
    logic [1:0] level = 2'd3;
    logic       pin_hi, busy_hi, done_hi;
    logic       pin_lo, busy_lo, done_lo;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    drv_led #(.p_scale(2), .p_mode(LED_ACTIVE_HIGH), .p_pwm_w(2)) dut_hi (
        .i_clk(clk), .i_rst(rst), .i_on(on), .i_off(off), .i_toggle(tog), .i_flash(fl),
        .i_count(count), .i_half(half), .i_level(level),
        .o_drv_led(pin_hi), .o_busy(busy_hi), .o_done(done_hi)
    );

    drv_led #(.p_scale(2), .p_mode(LED_ACTIVE_LOW), .p_pwm_w(2)) dut_lo (
        .i_clk(clk), .i_rst(rst), .i_on(on), .i_off(off), .i_toggle(tog), .i_flash(fl),
        .i_count(count), .i_half(half), .i_level(level),
        .o_drv_led(pin_lo), .o_busy(busy_lo), .o_done(done_lo)
    );

    typedef struct {
        logic [3:0]  cmd;     // {on, off, toggle, flash}
        logic [3:0]  cnt;
        logic [7:0]  hlf;
        int unsigned wait_n;  // edges after the pulse edge before sampling
        logic [2:0]  exp;     // {pin (active-high build), busy, done}
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic [3:0] c, input logic [3:0] n, input logic [7:0] h,
                                input int unsigned w, input logic [2:0] e);
        vec_t v;
        v.cmd = c; v.cnt = n; v.hlf = h; v.wait_n = w; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after an edge; the command is sampled on the next edge.
    task automatic pulse(input logic [3:0] c);
        {on, off, tog, fl} = c;
        step(1);
        {on, off, tog, fl} = 4'b0000;
    endtask

    initial begin
        int unsigned highs, lows, adj, bad;
        logic prev;

        vecs[0]  = mk(4'b0010, 4'd1, 8'd1, 1, 3'b100);
        vecs[1]  = mk(4'b0010, 4'd1, 8'd1, 9, 3'b000);
        vecs[2]  = mk(4'b0010, 4'd1, 8'd1, 9, 3'b100);
        vecs[3]  = mk(4'b0101, 4'd1, 8'd1, 1, 3'b000);
        vecs[4]  = mk(4'b1001, 4'd1, 8'd1, 1, 3'b100);
        vecs[5]  = mk(4'b1100, 4'd1, 8'd1, 1, 3'b000);
        vecs[6]  = mk(4'b0011, 4'd1, 8'd1, 1, 3'b110);
        vecs[7]  = mk(4'b0010, 4'd1, 8'd1, 1, 3'b110);
        vecs[8]  = mk(4'b0000, 4'd1, 8'd1, 1, 3'b010);
        vecs[9]  = mk(4'b0000, 4'd1, 8'd1, 2, 3'b001);
        vecs[10] = mk(4'b0000, 4'd1, 8'd1, 0, 3'b000);
        vecs[11] = mk(4'b1000, 4'd1, 8'd1, 1, 3'b100);
        vecs[12] = mk(4'b0001, 4'd1, 8'd1, 1, 3'b110);
        vecs[13] = mk(4'b0000, 4'd1, 8'd1, 6, 3'b001);
        vecs[14] = mk(4'b0001, 4'd1, 8'd1, 1, 3'b110);
        vecs[15] = mk(4'b1000, 4'd1, 8'd1, 1, 3'b100);
        vecs[16] = mk(4'b0000, 4'd1, 8'd1, 8, 3'b100);
        vecs[17] = mk(4'b0100, 4'd1, 8'd1, 1, 3'b000);
        vecs[18] = mk(4'b0001, 4'd1, 8'd0, 5, 3'b010);
        vecs[19] = mk(4'b0000, 4'd1, 8'd0, 2, 3'b001);
        vecs[20] = mk(4'b0000, 4'd1, 8'd0, 0, 3'b000);

        // Reset values
        #1 rst = 1'b0;
        #1;
        check("rst_pin_lo", pin_lo, 1);
        check("rst_pin_hi", pin_hi, 0);
        check("rst_busy", busy_hi, 0);
        check("rst_done", done_hi, 0);
        step(2);
        rst = 1'b1;
        step(2);

        // Active-low on/off with two-clock latency
        pulse(4'b1000);
        check("on_lat_k", pin_lo, 1);
        step(1);
        check("on_lat_k1", pin_lo, 0);
        step(4);
        check("on_hold", pin_lo, 0);
        pulse(4'b0100);
        check("off_lat_k", pin_lo, 0);
        step(1);
        check("off_lat_k1", pin_lo, 1);

        foreach (vecs[i]) begin
            count = vecs[i].cnt;
            half  = vecs[i].hlf;
            pulse(vecs[i].cmd);
            step(vecs[i].wait_n);
            check($sformatf("vec%0d_pin_hi", i), pin_hi, vecs[i].exp[2]);
            check($sformatf("vec%0d_pin_lo", i), pin_lo, !vecs[i].exp[2]);
            check($sformatf("vec%0d_busy_hi", i), busy_hi, vecs[i].exp[1]);
            check($sformatf("vec%0d_busy_lo", i), busy_lo, vecs[i].exp[1]);
            check($sformatf("vec%0d_done_hi", i), done_hi, vecs[i].exp[0]);
            check($sformatf("vec%0d_done_lo", i), done_lo, vecs[i].exp[0]);
        end

        // Finite flash: 2 flashes, 3 ticks of 4 clocks per phase
        count = 4'd2;
        half  = 8'd3;
        pulse(4'b0001);
        for (int j = 1; j <= 50; j++) begin
            step(1);
            check($sformatf("fin_pin_%0d", j), pin_hi, (j <= 48) && (((j - 1) / 12) % 2 == 0));
            check($sformatf("fin_busy_%0d", j), busy_hi, j < 48);
            check($sformatf("fin_done_%0d", j), done_hi, j == 48);
        end

        // Continuous flash, shortest half period
        count = 4'd0;
        half  = 8'd1;
        pulse(4'b0001);
        for (int j = 1; j <= 120; j++) begin
            step(1);
            check($sformatf("cont_pin_%0d", j), pin_hi, ((j - 1) / 4) % 2 == 0);
            check($sformatf("cont_busy_%0d", j), busy_hi, 1);
            check($sformatf("cont_done_%0d", j), done_hi, 0);
        end
        pulse(4'b0100);
        check("cont_off_busy", busy_hi, 0);
        check("cont_off_done", done_hi, 0);
        step(1);
        check("cont_off_pin", pin_hi, 0);

        // PWM brightness
        level = 2'd1;
        pulse(4'b1000);
        step(3);
        highs = 0; lows = 0; adj = 0; prev = 1'b0;
        for (int j = 0; j < 30; j++) begin
            step(1);
            if (pin_hi) highs++;
            if (!pin_lo) lows++;
            if (pin_hi && prev) adj++;
            prev = pin_hi;
        end
        check("pwm1_highs", highs, 10);
        check("pwm1_lo_lit", lows, 10);
        check("pwm1_adjacent", adj, 0);
        level = 2'd0;
        step(2);
        highs = 0;
        for (int j = 0; j < 12; j++) begin
            step(1);
            if (pin_hi) highs++;
        end
        check("pwm0_highs", highs, 0);
        level = 2'd3;
        step(2);
        highs = 0;
        for (int j = 0; j < 12; j++) begin
            step(1);
            if (pin_hi) highs++;
        end
        check("pwm3_highs", highs, 12);

        // Asynchronous reset in the middle of a flash
        pulse(4'b0100);
        count = 4'd2;
        half  = 8'd3;
        pulse(4'b0001);
        step(5);
        check("mid_pin_before", pin_hi, 1);
        #3 rst = 1'b0;
        #1;
        check("arst_pin_hi", pin_hi, 0);
        check("arst_pin_lo", pin_lo, 1);
        check("arst_busy", busy_hi, 0);
        check("arst_done", done_hi, 0);
        step(3);
        check("arst_hold_done", done_hi, 0);
        rst = 1'b1;
        bad = 0;
        for (int j = 0; j < 60; j++) begin
            step(1);
            if (done_hi || busy_hi || pin_hi) bad++;
        end
        check("arst_after_quiet", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
